sram22_param_macro: RTL and testbench
=====================================

SRAM22_PARAM_MACRO -- requirements
Module: sram22_param_macro

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bits per word.
REQ-002 Parameter ADDR_WIDTH, default 6: address bits; depth = 2^ADDR_WIDTH words.
REQ-003 Parameter WMASK_WIDTH, default 4: write-mask lanes; DATA_WIDTH SHALL be an integer multiple of WMASK_WIDTH; lane width LW = DATA_WIDTH/WMASK_WIDTH.
REQ-004 Parameter READ_LATENCY, default 1: read data latency in cycles; legal values 1 and 2 only.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request this cycle.
REQ-009 we  input  1  1 = write, 0 = read; sampled with the request.
REQ-010 wmask  input  WMASK_WIDTH  per-lane write enable; bit k covers din[k*LW +: LW].
REQ-011 addr  input  ADDR_WIDTH  word address.
REQ-012 din  input  DATA_WIDTH  write data.
REQ-013 dout  output  DATA_WIDTH  read data, registered.
REQ-014 dout_valid  output  1  one-cycle pulse qualifying dout.

Function
REQ-015 FSM states: INIT (clear memory) and READY; no other states.
REQ-016 INIT: one word per cycle set to all-zero, counter from 0 to depth-1; req_ready=0; requests ignored.
REQ-017 INIT -> READY on the cycle the word at depth-1 is cleared; clearing takes exactly depth cycles after reset deasserts.
REQ-018 READY: req_ready=1 every cycle; a request is accepted when req_valid && req_ready.
REQ-019 Accepted write: for each k with wmask[k]=1, lane k of mem[addr] takes din lane k on that edge; lanes with wmask[k]=0 unchanged; wmask all-zero is accepted and changes nothing.
REQ-020 Writes SHALL never be suppressed by any address/data value; every address 0..depth-1 writable.
REQ-021 Accepted read: dout_valid=1 and dout=mem[addr] exactly READ_LATENCY cycles after acceptance; back-to-back reads give one result per cycle in order.
REQ-022 Read in the cycle after a write to the same address returns the newly written data.
REQ-023 A write never asserts dout_valid; dout is unchanged by writes except as stated in REQ-031.
REQ-024 dout holds its last value whenever dout_valid=0 (apart from REQ-031).
REQ-025 Read and write are never simultaneous (single port); we selects exactly one.

Reset
REQ-026 While reset=1: state=INIT, clear counter=0, req_ready=0, dout_valid=0, dout=0, read pipeline valid bits cleared.
REQ-027 Reset asserted mid-operation (INIT or READY, reads in flight) discards in-flight reads (no dout_valid pulse) and restarts a full clear from address 0 on deassertion.
REQ-028 Memory contents are defined as all-zero only after INIT completes; reset alone does not clear memory in zero cycles.

Configuration
REQ-029 Macro SRAM22_X_ON_WRITE_EN selects write-cycle output behaviour.
REQ-030 Undefined: dout holds its previous value across accepted writes.
REQ-031 Defined: dout is driven to all-X in the cycle READ_LATENCY after an accepted write (simulation pessimism matching silicon); dout_valid stays 0; the next read restores defined data.

Verification (DATA_WIDTH=32, ADDR_WIDTH=6, WMASK_WIDTH=4, READ_LATENCY=1 unless stated)
REQ-032 Reset 1 cycle, deassert -> req_ready=0 for 64 cycles, 1 on cycle 65; read of addr 0x3F then returns 0x00000000 with dout_valid 1 cycle later.
REQ-033 Write addr 0x3F din 0xCAFEF00D wmask 0xF, then read 0x3F -> dout=0xCAFEF00D.
REQ-034 Write addr 5 din 0x11223344 wmask 0xF, then write din 0xAABBCCDD wmask 0x5, read addr 5 -> 0x11BB33DD.
REQ-035 READ_LATENCY=2: back-to-back reads of addrs 1,2,3 holding 0xA,0xB,0xC -> dout_valid high 3 consecutive cycles starting 2 cycles after first acceptance, data 0xA,0xB,0xC.
REQ-036 Read accepted, reset asserted next cycle -> no dout_valid pulse; req_ready low for 64 cycles after deassertion; prior data at that address reads 0.
REQ-037 With SRAM22_X_ON_WRITE_EN defined, write addr 2 -> dout all-X one cycle later, dout_valid=0; undefined -> dout retains prior read value.

Source files
------------

// File: rtl/sram22_param_macro.sv
// Single-port SRAM macro model: self-clearing INIT sweep, per-lane write mask, 1- or 2-cycle read latency.
// Define SRAM22_X_ON_WRITE_EN to drive dout to X in the output slot of an accepted write.
module sram22_param_macro #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 6,
  parameter int WMASK_WIDTH  = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   we,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  din,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = DATA_WIDTH / WMASK_WIDTH;

  typedef enum logic {INIT, READY} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_nxt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    accept, rd_acc, wr_acc;
  logic                    pipe_rd;
  logic [DATA_WIDTH-1:0]   pipe_dat;
  logic                    vld_q;
`ifdef SRAM22_X_ON_WRITE_EN
  logic                    pipe_wr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      INIT: begin
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (&clr_cnt) state_nxt = READY;
      end
      READY: ;
      default: state_nxt = INIT;
    endcase
  end

  // Gating with reset keeps ready/valid low in the very cycle reset rises.
  assign req_ready = (state == READY) && !reset;
  assign accept    = req_valid && req_ready;
  assign rd_acc    = accept && !we;
  assign wr_acc    = accept && we;

  always_ff @(posedge clk) begin
    if (!reset && state == INIT) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      for (int k = 0; k < WMASK_WIDTH; k++) begin
        if (wmask[k]) mem[addr][k*LW +: LW] <= din[k*LW +: LW];
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk) begin
        if (reset) begin
          pipe_rd <= 1'b0;
`ifdef SRAM22_X_ON_WRITE_EN
          pipe_wr <= 1'b0;
`endif
        end else begin
          pipe_rd <= rd_acc;
`ifdef SRAM22_X_ON_WRITE_EN
          pipe_wr <= wr_acc;
`endif
          if (rd_acc) pipe_dat <= mem[addr];
        end
      end
    end else begin : g_lat1
      assign pipe_rd  = rd_acc;
      assign pipe_dat = mem[addr];
`ifdef SRAM22_X_ON_WRITE_EN
      assign pipe_wr  = wr_acc;
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      dout  <= '0;
    end else begin
      vld_q <= pipe_rd;
      if (pipe_rd) dout <= pipe_dat;
`ifdef SRAM22_X_ON_WRITE_EN
      else if (pipe_wr) dout <= 'x;
`endif
    end
  end

  assign dout_valid = vld_q && !reset;

endmodule

// File: tb/tb_sram22_param_macro.sv
// Drives one latency-1 and one latency-2 instance with identical requests; a negedge monitor
// pops per-instance expectation queues filled from a word-level reference memory.
module tb_sram22_param_macro;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        we;
  logic [3:0]  wmask;
  logic [5:0]  addr;
  logic [31:0] din;
  logic        rdy1, rdy2, v1, v2;
  logic [31:0] dout1, dout2;

  sram22_param_macro #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .WMASK_WIDTH(4), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1), .we(we),
    .wmask(wmask), .addr(addr), .din(din), .dout(dout1), .dout_valid(v1));

  sram22_param_macro #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .WMASK_WIDTH(4), .READ_LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy2), .we(we),
    .wmask(wmask), .addr(addr), .din(din), .dout(dout2), .dout_valid(v2));

  typedef struct { logic [31:0] dat; int due; } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  logic [31:0] ref_mem [64];
  logic [31:0] last1, last2;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, got %0d cycles required fewer", cyc);
    $fatal(1);
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lane_bits(logic [3:0] m);
    logic [31:0] e;
    for (int k = 0; k < 4; k++) e[k*8 +: 8] = m[k] ? 8'hFF : 8'h00;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("reset_valid1", 64'(v1), 64'd0);
      check("reset_valid2", 64'(v2), 64'd0);
      q1.delete();
      q2.delete();
      last1 = '0;
      last2 = '0;
    end else begin
      if (v1) begin
        if (q1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious1: got dout_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = q1.pop_front();
          check("rd1_data", 64'(dout1), 64'(e.dat));
          check("rd1_latency", 64'(cyc), 64'(e.due));
        end
        last1 = dout1;
      end else begin
`ifndef SRAM22_X_ON_WRITE_EN
        check("hold1", 64'(dout1), 64'(last1));
`endif
      end
      if (v2) begin
        if (q2.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious2: got dout_valid=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = q2.pop_front();
          check("rd2_data", 64'(dout2), 64'(e.dat));
          check("rd2_latency", 64'(cyc), 64'(e.due));
        end
        last2 = dout2;
      end else begin
`ifndef SRAM22_X_ON_WRITE_EN
        check("hold2", 64'(dout2), 64'(last2));
`endif
      end
    end
  end

  // Hold reset two edges, release, and measure how long req_ready stays low.
  task automatic init_seq();
    int n;
    reset = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready1", 64'(rdy1), 64'd0);
    check("rst_ready2", 64'(rdy2), 64'd0);
    check("rst_dout1", 64'(dout1), 64'd0);
    check("rst_dout2", 64'(dout2), 64'd0);
    reset = 1'b0;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (rdy1) break;
      n++;
    end
    check("init_cycles", 64'(n), 64'd64);
    check("init_ready2", 64'(rdy2), 64'd1);
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic op(bit w, logic [5:0] a, logic [3:0] m, logic [31:0] d);
    exp_t e;
    req_valid = 1'b1;
    we        = w;
    addr      = a;
    wmask     = m;
    din       = d;
    check("ready", 64'(rdy1), 64'd1);
    if (w) begin
      ref_mem[a] = (ref_mem[a] & ~lane_bits(m)) | (d & lane_bits(m));
    end else begin
      e.dat = ref_mem[a];
      e.due = cyc + 1;
      q1.push_back(e);
      e.due = cyc + 2;
      q2.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; we = 1'b0; wmask = '0; addr = '0; din = '0;
    init_seq();

    op(0, 6'h3F, 4'h0, 32'h0);
    op(1, 6'h3F, 4'hF, 32'hCAFEF00D);
    op(0, 6'h3F, 4'h0, 32'h0);
    op(1, 6'd5, 4'hF, 32'h11223344);
    op(1, 6'd5, 4'h5, 32'hAABBCCDD);
    op(0, 6'd5, 4'h0, 32'h0);
    op(1, 6'd0, 4'h0, 32'hFFFFFFFF);
    op(0, 6'd0, 4'h0, 32'h0);

    op(1, 6'd1, 4'hF, 32'hA);
    op(1, 6'd2, 4'hF, 32'hB);
    op(1, 6'd3, 4'hF, 32'hC);
    op(0, 6'd1, 4'h0, 32'h0);
    op(0, 6'd2, 4'h0, 32'h0);
    op(0, 6'd3, 4'h0, 32'h0);
    idle(3);

    // Output behaviour in the slot of an accepted write.
    op(0, 6'd2, 4'h0, 32'h0);
    idle(3);
    op(1, 6'd2, 4'hF, 32'h55AA55AA);
    check("wr_no_valid1", 64'(v1), 64'd0);
`ifndef SRAM22_X_ON_WRITE_EN
    check("wr_hold1", 64'(dout1), 64'hB);
`endif
    idle(2);

    for (int a = 0; a < 64; a++) op(1, 6'(a), 4'hF, $urandom);
    for (int a = 0; a < 64; a++) op(0, 6'(a), 4'h0, 32'h0);

    repeat (400) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else op(1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom),
              4'($urandom), $urandom);
    end
    idle(3);

    // Reset right after a read is accepted: result must be discarded.
    op(1, 6'd5, 4'hF, 32'h12345678);
    req_valid = 1'b1; we = 1'b0; addr = 6'd5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    init_seq();
    op(0, 6'd5, 4'h0, 32'h0);
    op(0, 6'h3F, 4'h0, 32'h0);
    idle(4);

    check("queue1_empty", 64'(q1.size()), 64'd0);
    check("queue2_empty", 64'(q2.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
